// File: rtl/semimips_pkg.sv
// Shared definitions for the semiMIPS multicycle control path: state codes,
// opcode constants, ALU operand/operation codes and the control word layout.
package semimips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       jump;
        logic       branchbeq;
        logic       branchbne;
        logic       branchblez;
        logic       branchbgtz;
    } ctrl_t;

    // True for every opcode the core implements.
    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ) || (op == OP_BGTZ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control-path bundle between the main FSM (master) and the datapath (slave).
// Memory handshake: the FSM holds mem_read or mem_write high until the cycle
// in which mem_ready is 1; that cycle completes the access. mem_ready has no
// meaning while neither request is high.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       jump;
    logic       branchbeq;
    logic       branchbne;
    logic       branchblez;
    logic       branchbgtz;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               reg_write, memtoreg, regdst, alusrca, alusrcb, aluop, jump,
               branchbeq, branchbne, branchblez, branchbgtz, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               reg_write, memtoreg, regdst, alusrca, alusrcb, aluop, jump,
               branchbeq, branchbne, branchblez, branchbgtz, illegal_op, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: state plus the opcode latched in DECODE give the
// control word. Only FETCH looks at mem_ready (IR/PC load on completion).
module mc_ctrl_decode
    import semimips_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Per-state control word; anything not set stays 0.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.alusrcb  = SRCB_FOUR;
                ctrl_o.aluop    = ALUOP_ADD;
                ctrl_o.ir_write = mem_ready_i;
                ctrl_o.pc_write = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alusrcb = SRCB_IMM_SH2;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_I_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.memtoreg  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_RT;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.regdst    = 1'b1;
            end
            ST_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alusrca       = 1'b1;
                ctrl_o.alusrcb       = SRCB_RT;
                ctrl_o.aluop         = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                case (opcode_i)
                    OP_BEQ:  ctrl_o.branchbeq  = 1'b1;
                    OP_BNE:  ctrl_o.branchbne  = 1'b1;
                    OP_BLEZ: ctrl_o.branchblez = 1'b1;
                    OP_BGTZ: ctrl_o.branchbgtz = 1'b1;
                    default: ;
                endcase
            end
            ST_JUMP: begin
                ctrl_o.jump     = 1'b1;
                ctrl_o.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// semiMIPS multicycle main controller: state register, opcode latch and
// optional memory-wait watchdog. Outputs are all held at 0 during reset.
module mc_ctrl
    import semimips_pkg::*;
#(
    parameter int RDY_TIMEOUT = 0
) (
    input logic       clk,
    input logic       rst,
    mc_ctrl_if.master bus
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       timeout;
    logic       illegal;
    ctrl_t      ctrl;
    ctrl_t      ctrl_g;

    // Next state and opcode latch; unknown opcodes and watchdog expiry flag illegal.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        illegal  = timeout;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready)  state_d = ST_DECODE;
                else if (timeout)   state_d = ST_FETCH;
            end
            ST_DECODE: begin
                opcode_d = bus.opcode;
                case (bus.opcode)
                    OP_RTYPE:                         state_d = ST_R_EXEC;
                    OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
                    OP_ADDI:                          state_d = ST_I_EXEC;
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = ST_BRANCH;
                    OP_J:                             state_d = ST_JUMP;
                    default: begin
                        state_d = ST_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (bus.mem_ready)  state_d = ST_MEM_WB;
                else if (timeout)   state_d = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (bus.mem_ready || timeout) state_d = ST_FETCH;
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // State and opcode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    if (RDY_TIMEOUT > 0) begin : g_wdog
        localparam int CW = $clog2(RDY_TIMEOUT + 1);
        logic [CW-1:0] cnt_q, cnt_d;
        logic          in_wait;

        assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                         (state_q == ST_MEM_WR);
        assign timeout = in_wait && !bus.mem_ready && (cnt_q == CW'(RDY_TIMEOUT));

        // Count unanswered request cycles; restart whenever a wait state is (re)entered.
        always_comb begin
            cnt_d = cnt_q;
            if ((state_d != state_q) || timeout) cnt_d = '0;
            else if (in_wait && !bus.mem_ready)  cnt_d = cnt_q + CW'(1);
        end

        // Watchdog counter register.
        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end
    end else begin : g_no_wdog
        assign timeout = 1'b0;
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    assign ctrl_g = rst ? '0 : ctrl;

    assign bus.pc_write      = ctrl_g.pc_write;
    assign bus.pc_write_cond = ctrl_g.pc_write_cond;
    assign bus.ir_write      = ctrl_g.ir_write;
    assign bus.iord          = ctrl_g.iord;
    assign bus.mem_read      = ctrl_g.mem_read;
    assign bus.mem_write     = ctrl_g.mem_write;
    assign bus.reg_write     = ctrl_g.reg_write;
    assign bus.memtoreg      = ctrl_g.memtoreg;
    assign bus.regdst        = ctrl_g.regdst;
    assign bus.alusrca       = ctrl_g.alusrca;
    assign bus.alusrcb       = ctrl_g.alusrcb;
    assign bus.aluop         = ctrl_g.aluop;
    assign bus.jump          = ctrl_g.jump;
    assign bus.branchbeq     = ctrl_g.branchbeq;
    assign bus.branchbne     = ctrl_g.branchbne;
    assign bus.branchblez    = ctrl_g.branchblez;
    assign bus.branchbgtz    = ctrl_g.branchbgtz;
    assign bus.illegal_op    = rst ? 1'b0 : illegal;
    assign bus.state         = rst ? 4'd0 : state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main control FSM for the semiMIPS core. It sequences instruction fetch, decode, execute, memory access and write-back over a shared ALU and a single memory port. During branch and jump instructions it drives the branch-type strobes (`jump`, `branchbeq`, `branchbne`, `branchblez`, `branchbgtz`) into the branch control unit. That unit's 2-bit PC-select output, qualified by `pc_write_cond`, commits the branch target.

## Interface
Parameters:
- `RDY_TIMEOUT`, default 0: memory-wait watchdog in cycles. 0 disables it.

Ports:
- `clk`, input, 1: single system clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `opcode`, input, 6: IR[31:26]. Sampled in DECODE only.
- `mem_ready`, input, 1: memory port completion, valid while `mem_read` or `mem_write` is high.
- `pc_write`, output, 1: unconditional PC load.
- `pc_write_cond`, output, 1: PC load gated by the branch control unit.
- `ir_write`, output, 1: IR load.
- `iord`, output, 1: memory address select. 0 = PC, 1 = ALU out.
- `mem_read`, output, 1: memory read request.
- `mem_write`, output, 1: memory write request.
- `reg_write`, output, 1: register file write enable.
- `memtoreg`, output, 1: write-back source. 1 = MDR.
- `regdst`, output, 1: destination register. 1 = rd, 0 = rt.
- `alusrca`, output, 1: ALU A input. 0 = PC, 1 = rs.
- `alusrcb`, output, 2: ALU B input. 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `aluop`, output, 2: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `jump`, `branchbeq`, `branchbne`, `branchblez`, `branchbgtz`, output, 1 each: strobes to the branch control unit.
- `illegal_op`, output, 1: one-cycle pulse on an unknown opcode.
- `state`, output, 4: current state encoding, for debug.

## Operation
States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11. Encodings 12–15 are unused and go to FETCH on the next edge.

State behaviour (outputs not listed are 0):
- **FETCH**
  - Outputs: `mem_read`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00.
  - `ir_write` and `pc_write` are both driven equal to `mem_ready`.
  - Stays in FETCH while `mem_ready`=0. Goes to DECODE when `mem_ready`=1.
- **DECODE**
  - Outputs: `alusrca`=0, `alusrcb`=11, `aluop`=00 (precomputes the branch target).
  - Next state by opcode:
    - 000000 → R_EXEC
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 001000 (addi) → I_EXEC
    - 000100, 000101, 000110, 000111 → BRANCH
    - 000010 → JUMP
    - Any other value → FETCH, with `illegal_op`=1 in this cycle.
- **MEM_ADDR**
  - Outputs: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - Next state: lw → MEM_RD, sw → MEM_WR. The decoded opcode is registered in DECODE; the live input is not used here.
- **MEM_RD**
  - Outputs: `mem_read`=1, `iord`=1.
  - Waits on `mem_ready`, then goes to MEM_WB.
- **MEM_WB**
  - Outputs: `reg_write`=1, `memtoreg`=1, `regdst`=0.
  - Next state: FETCH.
- **MEM_WR**
  - Outputs: `mem_write`=1, `iord`=1.
  - Waits on `mem_ready`, then goes to FETCH.
- **R_EXEC**
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - Next state: R_WB.
- **R_WB**
  - Outputs: `reg_write`=1, `regdst`=1, `memtoreg`=0.
  - Next state: FETCH.
- **I_EXEC**
  - Outputs: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - Next state: I_WB.
- **I_WB**
  - Outputs: `reg_write`=1, `regdst`=0.
  - Next state: FETCH.
- **BRANCH**
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pc_write_cond`=1.
  - Exactly one branch strobe is high, chosen from the registered opcode: beq → `branchbeq`, bne → `branchbne`, blez → `branchblez`, bgtz → `branchbgtz`.
  - Next state: FETCH.
- **JUMP**
  - Outputs: `jump`=1, `pc_write`=1.
  - Next state: FETCH.

Output rules:
- Outputs are a combinational (Moore) decode of the state register and the registered opcode. The only exceptions are `ir_write` and `pc_write` in FETCH, which follow `mem_ready`.
- At most one of `mem_read` and `mem_write` is high in any cycle.
- At most one branch/jump strobe is high in any cycle.

## Timing
- Reset:
  - While `rst`=1, every output is forced to 0.
  - On the first edge with `rst`=1, `state` becomes 0 (FETCH) and the opcode register clears.
  - `mem_read` rises in the first cycle after `rst` falls.
- Reset mid-operation: `rst` overrides every transition, including memory waits. An outstanding request is dropped and no write strobe is issued in the reset cycle.
- Latency with `mem_ready` returned in the same cycle as the request:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch and jump: 3 cycles.
  - Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- Watchdog: when `RDY_TIMEOUT`>0, a memory-wait counter clears on entry to each wait state. Reaching `RDY_TIMEOUT` without `mem_ready` pulses `illegal_op` and returns to FETCH. Counter width is $clog2(RDY_TIMEOUT+1).
- `mem_ready` is ignored in every state that does not issue a request.

## Structure
- `semimips_pkg` holds the state localparams, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J) and the ALUOP/ALUSRCB codes. The ALU control and branch control units share these.
- Sub-module `mc_ctrl_decode`: combinational state + registered opcode → control outputs.
- The FSM register, opcode register and watchdog stay in `mc_ctrl`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → all outputs 0. After release, `state`=0 and `mem_read`=1.
- **R-type:** opcode 000000, `mem_ready` always 1 → states 0,1,6,7,0. `reg_write`=1 with `regdst`=1 in the 4th cycle.
- **lw with memory waits:** opcode 100011, `mem_ready` low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4,0. `memtoreg`=1 in state 4.
- **Branch strobes:** opcodes 000100, 000101, 000110, 000111, then 000010 → in state 10 only `branchbeq` / `branchbne` / `branchblez` / `branchbgtz` respectively is high, with `pc_write_cond`=1. In state 11 `jump`=1 and `pc_write`=1.
- **Illegal opcode:** opcode 111111 → `illegal_op`=1 for exactly one cycle in DECODE, then `state`=0.
- **Reset during MEM_WR:** `rst` asserted while `mem_write`=1 → `mem_write`=0 in the same cycle and `state`=0 on the next edge. With `RDY_TIMEOUT`=3 and `mem_ready` stuck at 0, FETCH exits with an `illegal_op` pulse after 3 wait cycles.
